// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register addresses,
// the IRQ_ID read layout and the write-decode helper.
package irq_ctrl_pkg;

    localparam logic [4:0] IRQ_MASK = 5'h00;
    localparam logic [4:0] IRQ_EDGE = 5'h04;
    localparam logic [4:0] IRQ_PEND = 5'h08;
    localparam logic [4:0] IRQ_SWI  = 5'h0C;
    localparam logic [4:0] IRQ_ID   = 5'h10;

    typedef struct packed {
        logic        valid;
        logic [30:0] id;
    } irq_id_v;

    function automatic logic we_find(input logic we, input logic [4:0] addr,
                                     input logic [4:0] target);
        return we && (addr == target);
    endfunction

endpackage

// File: rtl/irq_ctrl_reg_we.sv
// Plain write-enabled register with asynchronous active-low clear.
module irq_ctrl_reg_we #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         we,
    input  logic [W-1:0] wd,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (we) begin
            q <= wd;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level capture into a pending latch,
// mask, software trigger and a fixed-priority (lowest index first) encoder.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int irq_n = 8,
    parameter int id_w  = (irq_n > 1) ? $clog2(irq_n) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       addr,
    input  logic             we,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic [irq_n-1:0] irq_src,
    output logic             irq,
    output logic [id_w-1:0]  irq_id
);

    logic [irq_n-1:0] mask_reg;
    logic [irq_n-1:0] edge_reg;
    logic [irq_n-1:0] pend_reg;
    logic [irq_n-1:0] pend_next;
    logic [irq_n-1:0] src_prev_reg;
    logic [irq_n-1:0] set_v;
    logic [irq_n-1:0] clr_v;
    logic [irq_n-1:0] swi_v;
    logic [irq_n-1:0] active;
    logic [irq_n-1:0] wd_low;
    logic             we_mask;
    logic             we_edge;
    logic             we_pend;
    logic             we_swi;
    irq_id_v          id_rd;
    logic             unused_wd;

    assign wd_low    = wd[irq_n-1:0];
    assign unused_wd = ^wd[31:irq_n];

    assign we_mask = we_find(we, addr, IRQ_MASK);
    assign we_edge = we_find(we, addr, IRQ_EDGE);
    assign we_pend = we_find(we, addr, IRQ_PEND);
    assign we_swi  = we_find(we, addr, IRQ_SWI);

    irq_ctrl_reg_we #(.W(irq_n)) u_mask (
        .clk  (clk),
        .rstn (rstn),
        .we   (we_mask),
        .wd   (wd_low),
        .q    (mask_reg)
    );

    irq_ctrl_reg_we #(.W(irq_n)) u_edge (
        .clk  (clk),
        .rstn (rstn),
        .we   (we_edge),
        .wd   (wd_low),
        .q    (edge_reg)
    );

    assign swi_v = we_swi  ? wd_low : '0;
    assign clr_v = we_pend ? wd_low : '0;

    // Set takes priority over a same-cycle W1C so no event is dropped.
    generate
        for (genvar gi = 0; gi < irq_n; gi++) begin : g_src
            assign set_v[gi] = (edge_reg[gi] ? (irq_src[gi] & ~src_prev_reg[gi])
                                             : irq_src[gi]) | swi_v[gi];
            assign pend_next[gi] = set_v[gi] | (pend_reg[gi] & ~clr_v[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_reg     <= '0;
            src_prev_reg <= '0;
        end else begin
            pend_reg     <= pend_next;
            src_prev_reg <= irq_src;
        end
    end

    assign active = pend_reg & mask_reg;
    assign irq    = |active;

    // Walk from the top down so the lowest active index wins.
    always_comb begin
        irq_id = '0;
        for (int i = irq_n - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_id = id_w'(i);
            end
        end
    end

    always_comb begin
        id_rd       = '0;
        id_rd.valid = irq;
        id_rd.id    = 31'(irq_id);
        rd          = '0;
        case (addr)
            IRQ_EDGE: rd = 32'(edge_reg);
            IRQ_PEND: rd = 32'(pend_reg);
            IRQ_SWI:  rd = '0;
            IRQ_ID:   rd = id_rd;
            default:  rd = 32'(mask_reg);
        endcase
    end

endmodule
